adder_meas_driver: RTL

Measurement initiator for the instrumented ripple adder. It accepts a measurement command from the logic-analyser side: operands A/B plus a repeat count. It drives the operands into the adder, fires the adder's launch/measure handshake once per repeat, and collects the ring-oscillator count returned after each run. When the last run finishes it offers one summary record (sum, min, max, status) back to the logic-analyser side. It sits between the LA register interface and the instrumented adder core inside the wrapped project.

---
 rtl/adder_meas_pkg.sv | 20 ++
 rtl/adder_meas_stats.sv | 35 +++
 rtl/adder_meas_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adder_meas_pkg.sv
// Shared states and default widths for the adder measurement driver.
// Optional WAIT watchdog is enabled by defining ADDER_MEAS_TIMEOUT_EN.
package adder_meas_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int REP_W  = 8;
  localparam int SUM_W  = CNT_W + REP_W;

  localparam logic [CNT_W-1:0] MIN_RST = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT,
    REPORT
  } state_t;

endpackage

// File: rtl/adder_meas_stats.sv
// Sum/min/max/runs accumulator over the ring counts of completed runs.
// Cleared at command accept, sampled once per completed run.
module adder_meas_stats #(
  parameter int CNT_W = adder_meas_pkg::CNT_W,
  parameter int REP_W = adder_meas_pkg::REP_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   en,
  input  logic [CNT_W-1:0]       count,
  output logic [CNT_W+REP_W-1:0] sum,
  output logic [CNT_W-1:0]       lo,
  output logic [CNT_W-1:0]       hi,
  output logic [REP_W-1:0]       runs
);
  import adder_meas_pkg::*;

  localparam int SW = CNT_W + REP_W;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum  <= '0;
      lo   <= '1;
      hi   <= '0;
      runs <= '0;
    end else if (en) begin
      sum  <= sum + SW'(count);
      runs <= runs + REP_W'(1);
      if (count < lo) lo <= count;
      if (count > hi) hi <= count;
    end
  end

endmodule

// File: rtl/adder_meas_driver.sv
// Measurement initiator: launches repeated adder runs, reports stats.
// Define ADDER_MEAS_TIMEOUT_EN to compile in the WAIT watchdog.
module adder_meas_driver #(
  parameter int DATA_W      = adder_meas_pkg::DATA_W,
  parameter int CNT_W       = adder_meas_pkg::CNT_W,
  parameter int REP_W       = adder_meas_pkg::REP_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_W-1:0]      cmd_a,
  input  logic [DATA_W-1:0]      cmd_b,
  input  logic [REP_W-1:0]       cmd_rep,
  output logic [DATA_W-1:0]      adder_a,
  output logic [DATA_W-1:0]      adder_b,
  output logic                   adder_go,
  input  logic                   adder_done,
  input  logic [CNT_W-1:0]       adder_count,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CNT_W+REP_W-1:0] res_sum,
  output logic [CNT_W-1:0]       res_min,
  output logic [CNT_W-1:0]       res_max,
  output logic [REP_W-1:0]       res_runs,
  output logic                   res_timeout
);
  import adder_meas_pkg::*;

  state_t           state;
  logic [REP_W-1:0] target;
  logic [REP_W-1:0] tries;
  logic             accept;
  logic             hit;
  logic             tmo;
  logic             step;
  logic             last;

  assign accept = cmd_valid && cmd_ready;
  assign hit    = (state == WAIT) && adder_done;
  assign step   = hit || tmo;
  // Aborted runs count toward the target just like completed ones.
  assign last   = (tries + REP_W'(1)) == target;

`ifdef ADDER_MEAS_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYC);

  logic [WC_W-1:0] wcnt;

  assign tmo = (state == WAIT) && !adder_done &&
               (wcnt == WC_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      wcnt        <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (accept)   res_timeout <= 1'b0;
      else if (tmo) res_timeout <= 1'b1;
      if (state == ARM)       wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + WC_W'(1);
    end
  end
`else
  assign tmo         = 1'b0;
  assign res_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      adder_go  <= 1'b0;
      res_valid <= 1'b0;
      adder_a   <= '0;
      adder_b   <= '0;
      target    <= '0;
      tries     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            adder_a   <= cmd_a;
            adder_b   <= cmd_b;
            target    <= (cmd_rep == '0) ? REP_W'(1) : cmd_rep;
            tries     <= '0;
            cmd_ready <= 1'b0;
            state     <= LOAD;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          adder_go <= 1'b1;
          state    <= ARM;
        end
        ARM: begin
          adder_go <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (step) begin
            tries <= tries + REP_W'(1);
            if (last) begin
              res_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              adder_go <= 1'b1;
              state    <= ARM;
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  adder_meas_stats #(
    .CNT_W(CNT_W),
    .REP_W(REP_W)
  ) u_stats (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_n),
    .clear(accept),
    .en   (hit),
    .count(adder_count),
    .sum  (res_sum),
    .lo   (res_min),
    .hi   (res_max),
    .runs (res_runs)
  );

endmodule
